// File: rtl/blob_pixel_feeder.sv
// Reads one RGB565 frame from a show-ahead FIFO, binarizes each pixel by luma threshold,
// streams it to the blob counter on demand, then captures the counter's result.
module blob_pixel_feeder #(
    parameter int IMG_COL = 800,
    parameter int IMG_ROW = 600,
    parameter bit INVERT  = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_thresh,
    input  logic [15:0] i_rd_data,
    input  logic        i_rd_empty,
    output logic        o_rd_req,
    output logic        o_valid,
    output logic        o_seq,
    input  logic        i_req,
    input  logic        i_result_valid,
    input  logic [7:0]  i_result,
    output logic [7:0]  o_count,
    output logic        o_done,
    output logic        o_underrun,
    output logic [2:0]  o_dbg_state
);

    localparam int          TOTAL   = IMG_COL * IMG_ROW;
    localparam logic [18:0] TOTAL_C = 19'(TOTAL);
    localparam int          COL_W   = (IMG_COL > 1) ? $clog2(IMG_COL) : 1;
    localparam int          ROW_W   = (IMG_ROW > 1) ? $clog2(IMG_ROW + 1) : 1;

    // Handshake: a pixel is consumed on every cycle the counter holds i_req high while
    // streaming; o_rd_req pops the FIFO head in that same cycle unless the FIFO is empty.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        STREAM   = 3'd2,
        WAIT_RES = 3'd3,
        CAPTURE  = 3'd4
    } state_t;

    state_t            state, state_next;
    logic [7:0]        thresh_r;
    logic [18:0]       pix_cnt;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [7:0]        luma;
    logic              fg;
    logic              demand;
    logic              frame_end;

    assign o_dbg_state = state;

    // Max luma is 62 + 63 + 62 = 187, so 8 bits never overflow.
    always_comb begin
        luma = {2'b00, i_rd_data[15:11], 1'b0}
             + {2'b00, i_rd_data[10:5]}
             + {2'b00, i_rd_data[4:0], 1'b0};
        fg   = (luma >= thresh_r) ^ INVERT;
    end

    always_comb begin
        state_next = state;
        demand     = 1'b0;
        frame_end  = 1'b0;
        o_rd_req   = 1'b0;
        case (state)
            IDLE:     if (i_start) state_next = ARM;
            ARM:      if (!i_rd_empty) state_next = STREAM;
            STREAM: begin
                if (pix_cnt < TOTAL_C) begin
                    demand   = i_req;
                    o_rd_req = i_req & ~i_rd_empty;
                end else begin
                    frame_end  = 1'b1;
                    state_next = WAIT_RES;
                end
            end
            WAIT_RES: if (i_result_valid) state_next = CAPTURE;
            CAPTURE:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            thresh_r   <= 8'd0;
            pix_cnt    <= 19'd0;
            col        <= '0;
            row        <= '0;
            o_valid    <= 1'b0;
            o_seq      <= 1'b0;
            o_count    <= 8'd0;
            o_done     <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        thresh_r   <= i_thresh;
                        pix_cnt    <= 19'd0;
                        col        <= '0;
                        row        <= '0;
                        o_underrun <= 1'b0;
                    end
                end
                ARM: begin
                    if (!i_rd_empty) o_valid <= 1'b1;
                end
                STREAM: begin
                    if (demand) begin
                        pix_cnt <= pix_cnt + 19'd1;
                        // An underrun pixel still counts, but as background.
                        o_seq   <= fg & ~i_rd_empty;
                        if (i_rd_empty) o_underrun <= 1'b1;
                        if (col == COL_W'(IMG_COL - 1)) begin
                            col <= '0;
                            row <= row + ROW_W'(1);
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                    if (frame_end) o_seq <= 1'b0;
                end
                WAIT_RES: begin
                    if (i_result_valid) begin
                        o_count <= i_result;
                        o_done  <= 1'b1;
                        o_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
